// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush scheduler for a 5-stage RV32I pipeline.
//
// Resolves data-memory wait, taken-branch redirect, FENCE.I drain, load-use
// hazards and instruction-fetch wait into one stall/flush pair per pipeline
// buffer plus a PC hold. No buffer ever sees stall and flush together.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   id_rs1/id_rs2        source register indices of the ID instruction
//   id_use_rs1/rs2       ID instruction actually reads that source
//   id_fence_i           ID instruction is FENCE.I
//   ex_rd, ex_mem_read   destination and load flag of the EX instruction
//   ex_branch_taken      EX resolved a taken branch/jump
//   mem_req, mem_ack     MEM-stage data access request / completion
//   imem_ready           fetch data valid this cycle
//   pc_stall             hold the PC
//   *_stall, *_flush     per-buffer hold / bubble insert (IF2ID..MEM2WB)
//   busy                 scheduler is in MEM_WAIT or DRAIN
//
// Optional build macro CTRL_PERF_EN adds stall_cycles / flush_events
// performance counters (CNT_W bits, wrapping).
//
// All control outputs are combinational from the FSM state and inputs.

module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_fence_i,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             imem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
`ifdef CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
`endif
  output logic             busy
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Elaboration-time parameter sanity
  if (DRAIN_CYCLES == 0) begin : g_bad_drain
    $error("pipeline_hazard_ctrl: DRAIN_CYCLES must be at least 1");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("pipeline_hazard_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;

  logic mem_wait;
  logic load_use;
  logic fence_accept;

  // Hazard detection; x0 is hard-wired zero so it never creates a dependency
  assign mem_wait = mem_req && !mem_ack;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  // FENCE.I is also accepted in the ack cycle of MEM_WAIT: the pipe advances
  // that cycle, so the fence must start draining there rather than slip into EX.
  assign fence_accept = (state != DRAIN) && id_fence_i && !mem_wait && !ex_branch_taken;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt = MEM_WAIT;
        end else if (fence_accept) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          if (fence_accept) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
          end else begin
            state_nxt = RUN;
          end
        end
      end
      DRAIN: begin
        // A memory wait freezes the whole back end, so the drain count
        // is held rather than spent while nothing retires.
        if (!mem_wait) begin
          if (drain_cnt == '0) begin
            state_nxt = RUN;
          end else begin
            drain_cnt_nxt = drain_cnt - DW'(1);
          end
        end
      end
      default: begin
        state_nxt     = RUN;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic, strict priority; reset forces everything low
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    mem_wb_flush = 1'b0;
    busy         = 1'b0;
    if (!ARESET) begin
      busy = (state != RUN);
      if (mem_wait) begin
        // Freeze everything upstream of MEM and bubble into WB
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if ((state == DRAIN) || fence_accept || load_use) begin
        // Hold the front end and inject a bubble into EX
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_EN
  logic branch_flush;
  assign branch_flush = !ARESET && !mem_wait && ex_branch_taken;

  // Performance counters, wrap naturally at 2^CNT_W
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_flush) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3).
module tb_pipeline_hazard_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_fence_i;
  logic        ex_mem_read, ex_branch_taken, mem_req, mem_ack, imem_ready;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, busy;
`ifdef CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_fence_i(id_fence_i), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .imem_ready(imem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
`ifdef CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  // Output vector: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f, busy
  logic [9:0] outs;
  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, busy};

  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_HOLD = 10'b1100100000; // pc, if_id stall, id_ex flush
  localparam logic [9:0] O_BR   = 10'b0010100000; // if_id, id_ex flush
  localparam logic [9:0] O_MEM  = 10'b1101010010; // four stalls + mem_wb flush
  localparam logic [9:0] O_IM   = 10'b1010000000; // pc stall, if_id flush
  localparam logic [9:0] O_BUSY = 10'b0000000001;

  task automatic idle();
    ARESET = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_fence_i = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; imem_ready = 1'b1;
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    idle(); ARESET = 1'b1; set_lu(5'd5); id_fence_i = 1'b1; imem_ready = 1'b0;
    step(); step();
    #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", outs, O_NONE); end
    step(); idle(); #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL reset_release got=%b exp=%b", outs, O_NONE); end
    step();
  endtask

  task automatic test_load_use();
    idle(); set_lu(5'd5); #2;
    checks++;
    if (outs !== O_HOLD) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", outs, O_HOLD); end
    step(); idle(); #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL lu_after got=%b exp=%b", outs, O_NONE); end
    step(); set_lu(5'd0); id_use_rs2 = 1'b1; #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", outs, O_NONE); end
    step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; #2;
    checks++;
    if (outs !== O_HOLD) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", outs, O_HOLD); end
    step(); id_use_rs2 = 1'b0; id_rs1 = 5'd7; #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL lu_unused_src got=%b exp=%b", outs, O_NONE); end
    step(); idle();
  endtask

  task automatic test_branch_vs_load_use();
    idle(); set_lu(5'd9); ex_branch_taken = 1'b1; #2;
    checks++;
    if (outs !== O_BR) begin failures++; $display("FAIL br_over_lu got=%b exp=%b", outs, O_BR); end
    step(); idle(); ex_branch_taken = 1'b1; imem_ready = 1'b0; #2;
    checks++;
    if (outs !== O_BR) begin failures++; $display("FAIL br_over_imem got=%b exp=%b", outs, O_BR); end
    step(); idle(); imem_ready = 1'b0; #2;
    checks++;
    if (outs !== O_IM) begin failures++; $display("FAIL imem_wait got=%b exp=%b", outs, O_IM); end
    step(); idle();
  endtask

  task automatic test_mem_wait();
    logic [9:0] exp;
    idle();
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1; mem_ack = 1'b0; ex_branch_taken = 1'b1; set_lu(5'd3); #2;
      exp = (i == 0) ? O_MEM : (O_MEM | O_BUSY);
      checks++;
      if (outs !== exp) begin failures++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs, exp); end
      step();
    end
    mem_ack = 1'b1; #2;
    checks++;
    if (outs !== (O_BR | O_BUSY)) begin failures++; $display("FAIL mem_ack_branch got=%b exp=%b", outs, O_BR | O_BUSY); end
    step(); idle(); #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL mem_after got=%b exp=%b", outs, O_NONE); end
    step();
  endtask

  task automatic test_fence();
    logic [9:0] exp;
    idle(); id_fence_i = 1'b1; #2;
    checks++;
    if (outs !== O_HOLD) begin failures++; $display("FAIL fence_enter got=%b exp=%b", outs, O_HOLD); end
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      #2;
      exp = (i < 3) ? (O_HOLD | O_BUSY) : O_NONE;
      checks++;
      if (outs !== exp) begin failures++; $display("FAIL fence_drain[%0d] got=%b exp=%b", i, outs, exp); end
      step();
    end
    // Branch in the fence cycle squashes it: no drain
    id_fence_i = 1'b1; ex_branch_taken = 1'b1; #2;
    checks++;
    if (outs !== O_BR) begin failures++; $display("FAIL fence_branch got=%b exp=%b", outs, O_BR); end
    step(); idle(); #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL fence_squashed got=%b exp=%b", outs, O_NONE); end
    step();
    // Branch during drain flushes but does not shorten the drain
    id_fence_i = 1'b1; step(); idle(); ex_branch_taken = 1'b1; #2;
    checks++;
    if (outs !== (O_BR | O_BUSY)) begin failures++; $display("FAIL drain_branch got=%b exp=%b", outs, O_BR | O_BUSY); end
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      exp = (i < 2) ? (O_HOLD | O_BUSY) : O_NONE;
      checks++;
      if (outs !== exp) begin failures++; $display("FAIL drain_after_br[%0d] got=%b exp=%b", i, outs, exp); end
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    idle(); id_fence_i = 1'b1; step(); idle(); #2;
    checks++;
    if (outs !== (O_HOLD | O_BUSY)) begin failures++; $display("FAIL rst_drain1 got=%b exp=%b", outs, O_HOLD | O_BUSY); end
    step(); ARESET = 1'b1; #2;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL rst_drain2 got=%b exp=%b", outs, O_NONE); end
    step(); ARESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (outs !== O_NONE) begin failures++; $display("FAIL rst_drain_after[%0d] got=%b exp=%b", i, outs, O_NONE); end
      step();
    end
  endtask

`ifdef CTRL_PERF_EN
  task automatic test_perf();
    idle(); ARESET = 1'b1; step(); idle();
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1; mem_ack = 1'b0; step();
    end
    mem_ack = 1'b1; step(); idle(); ex_branch_taken = 1'b1; step(); idle(); #2;
    checks++;
    if (stall_cycles !== 32'd4) begin failures++; $display("FAIL perf_stall got=%0d exp=4", stall_cycles); end
    checks++;
    if (flush_events !== 32'd1) begin failures++; $display("FAIL perf_flush got=%0d exp=1", flush_events); end
    step();
  endtask
`endif

  initial begin
    idle(); ARESET = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_fence();
    test_reset_mid_drain();
`ifdef CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
